// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: writeback source select and MEM/WB control fields.
// Used by the MEM/WB stage, its interface and its testbench.
package mips_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control and load-data half of the MEM/WB pipeline register
    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  mem_block;
        logic        is_LB_SB;
        logic        reg_write;
        wb_sel_e     wb_sel;
        logic [4:0]  dest_reg;
    } wb_ctl_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-stage to writeback bundle: stage inputs from MEM, register-file write port out.
// master = MEM side driving the stage, slave = the MEM/WB stage itself.
interface mem_wb_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) ();
    logic              freeze;
    logic              flush;
    logic              in_valid;
    logic [0:3][7:0]   cache_data_out;
    logic [1:0]        mem_block;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_plus4;
    logic              is_LB_SB;
    logic              reg_write;
    wb_sel_e           wb_sel;
    logic [4:0]        dest_reg;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output freeze, flush, in_valid, cache_data_out, mem_block, alu_result,
               pc_plus4, is_LB_SB, reg_write, wb_sel, dest_reg,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  freeze, flush, in_valid, cache_data_out, mem_block, alu_result,
               pc_plus4, is_LB_SB, reg_write, wb_sel, dest_reg,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: full word, or byte [mem_block] (0 = MSB) sign-extended.
// Latency: combinational. Backpressure: none.
// Assumes DATA_W >= 32.
module load_align #(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       word,
    input  logic [1:0]        mem_block,
    input  logic              is_LB_SB,
    output logic [DATA_W-1:0] value
);
    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = word[31:24];
        case (mem_block)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            2'd3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        value = DATA_W'(word);
        if (is_LB_SB) begin
            value = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux and retire/stall counters.
// Latency: 1 cycle from capture edge to rf_* outputs (all outputs registered-only).
// Backpressure: freeze or flush inserts a bubble; the MEM stage re-presents the held instruction.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_stage_if.slave    stg,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    logic              valid_q;
    wb_ctl_t           ctl_d;
    wb_ctl_t           ctl_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] pc_plus4_q;
    logic [DATA_W-1:0] load_value;
    logic [CNT_W-1:0]  retired_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              rf_we_int;

    always_comb begin
        ctl_d.word      = {stg.cache_data_out[0], stg.cache_data_out[1],
                           stg.cache_data_out[2], stg.cache_data_out[3]};
        ctl_d.mem_block = stg.mem_block;
        ctl_d.is_LB_SB  = stg.is_LB_SB;
        ctl_d.reg_write = stg.reg_write;
        ctl_d.wb_sel    = stg.wb_sel;
        ctl_d.dest_reg  = stg.dest_reg;
    end

    // A bubble only drops valid; payload fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            ctl_q        <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
        end else if (stg.freeze || stg.flush) begin
            valid_q <= 1'b0;
        end else begin
            valid_q      <= stg.in_valid;
            ctl_q        <= ctl_d;
            alu_result_q <= stg.alu_result;
            pc_plus4_q   <= stg.pc_plus4;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .word      (ctl_q.word),
        .mem_block (ctl_q.mem_block),
        .is_LB_SB  (ctl_q.is_LB_SB),
        .value     (load_value)
    );

    assign rf_we_int = valid_q && ctl_q.reg_write && (ctl_q.dest_reg != REG_ZERO);

    always_comb begin
        stg.rf_wdata = '0;
        case (ctl_q.wb_sel)
            WB_ALU:  stg.rf_wdata = alu_result_q;
            WB_MEM:  stg.rf_wdata = load_value;
            WB_LINK: stg.rf_wdata = pc_plus4_q;
            default: stg.rf_wdata = '0;
        endcase
    end

    assign stg.rf_we    = rf_we_int;
    assign stg.rf_waddr = ctl_q.dest_reg;

    // Stores and other non-writing instructions still count as retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (rf_we_int || (valid_q && !ctl_q.reg_write)) begin
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
            end
            if (stg.freeze) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
endmodule
